// File: rtl/iter_divider_pkg.sv
// Shared types and helpers for the iterative integer divider.
package iter_divider_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_t;

    function automatic logic [XLEN-1:0] cond_neg(
        input logic            neg,
        input logic [XLEN-1:0] v
    );
        return neg ? (~v + XLEN'(1)) : v;
    endfunction

endpackage

// File: rtl/div_restore_step.sv
// One restoring-division iteration: shift in a bit, trial-subtract.
module div_restore_step
    import iter_divider_pkg::*;
(
    input  logic [XLEN:0]   rem_i,
    input  logic [XLEN-1:0] divisor_i,
    input  logic            bit_i,
    output logic [XLEN:0]   rem_o,
    output logic            q_bit_o
);

    logic [XLEN+1:0] shifted;
    logic [XLEN+1:0] diff;

    always_comb begin
        shifted = {rem_i, bit_i};
        diff    = shifted - {2'b00, divisor_i};
        q_bit_o = ~diff[XLEN+1];
        rem_o   = q_bit_o ? diff[XLEN:0] : shifted[XLEN:0];
    end

endmodule

// File: rtl/iter_divider.sv
// Multi-cycle radix-2 restoring divider for DIV/MOD, signed and unsigned.
module iter_divider
    import iter_divider_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush_i,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic            opd_unsigned_i,
    input  logic            op_mod_i,
    input  logic [XLEN-1:0] dividend_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic            resp_valid_o,
    input  logic            resp_ready_i,
    output logic [XLEN-1:0] result_o
);

    div_state_t      state;
    logic [4:0]      cnt;
    logic [XLEN:0]   rem;
    logic [XLEN-1:0] quo;
    logic [XLEN-1:0] dvs;
    logic [XLEN-1:0] result_q;
    logic            neg_q;
    logic            neg_r;
    logic            op_mod;

    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;
    logic [XLEN:0]   rem_nx;
    logic            q_bit;
    logic [XLEN-1:0] q_fin;
    logic [XLEN-1:0] fix;

    always_comb begin
        a_neg = ~opd_unsigned_i & dividend_i[XLEN-1];
        b_neg = ~opd_unsigned_i & divisor_i[XLEN-1];
        a_mag = cond_neg(a_neg, dividend_i);
        b_mag = cond_neg(b_neg, divisor_i);
        q_fin = {quo[XLEN-2:0], q_bit};
        fix   = op_mod ? cond_neg(neg_r, rem_nx[XLEN-1:0])
                       : cond_neg(neg_q, q_fin);
    end

    // quo starts as the dividend magnitude; its MSB feeds each step
    // while quotient bits shift in from the bottom.
    div_restore_step u_step (
        .rem_i     (rem),
        .divisor_i (dvs),
        .bit_i     (quo[XLEN-1]),
        .rem_o     (rem_nx),
        .q_bit_o   (q_bit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            rem      <= '0;
            quo      <= '0;
            dvs      <= '0;
            result_q <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            op_mod   <= 1'b0;
        end else if (flush_i) begin
            state <= IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req_valid_i) begin
                        op_mod <= op_mod_i;
                        neg_q  <= a_neg ^ b_neg;
                        neg_r  <= a_neg;
                        if (divisor_i == '0) begin
                            state    <= DONE;
                            result_q <= '1;
                        end else begin
                            state <= CALC;
                            cnt   <= 5'd31;
                            rem   <= '0;
                            quo   <= a_mag;
                            dvs   <= b_mag;
                        end
                    end
                end
                CALC: begin
                    rem <= rem_nx;
                    quo <= q_fin;
                    cnt <= cnt - 5'd1;
                    if (cnt == '0) begin
                        state    <= DONE;
                        result_q <= fix;
                    end
                end
                DONE: begin
                    if (resp_ready_i) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign req_ready_o  = (state == IDLE);
    assign resp_valid_o = (state == DONE);
    assign result_o     = result_q;

endmodule

// File: tb/tb_iter_divider.sv
// Randomized self-checking bench for iter_divider against an arithmetic model.
module tb_iter_divider;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush_i = 1'b0;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic        opd_unsigned_i = 1'b0;
    logic        op_mod_i = 1'b0;
    logic [31:0] dividend_i = '0;
    logic [31:0] divisor_i = '0;
    logic        resp_valid_o;
    logic        resp_ready_i = 1'b0;
    logic [31:0] result_o;

    int n_chk = 0;
    int n_pass = 0;

    iter_divider dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush_i        (flush_i),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .opd_unsigned_i (opd_unsigned_i),
        .op_mod_i       (op_mod_i),
        .dividend_i     (dividend_i),
        .divisor_i      (divisor_i),
        .resp_valid_o   (resp_valid_o),
        .resp_ready_i   (resp_ready_i),
        .result_o       (result_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got %h exp %h", tag, got, exp);
    endtask

    // Truncating division on 64-bit integers; zero divisor gives all ones.
    function automatic logic [31:0] ref_div(input logic u, input logic m,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        longint sa, sb, q, r;
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (u) begin
            sa = longint'(a);
            sb = longint'(b);
        end else begin
            sa = longint'(signed'(a));
            sb = longint'(signed'(b));
        end
        q = sa / sb;
        r = sa % sb;
        return m ? r[31:0] : q[31:0];
    endfunction

    task automatic do_op(input string tag, input logic u, input logic m,
                         input logic [31:0] a, input logic [31:0] b,
                         input int hold);
        logic [31:0] exp;
        int lat;
        int exp_lat;
        exp     = ref_div(u, m, a, b);
        exp_lat = (b == 32'd0) ? 1 : 33;
        @(negedge clk);
        chk({tag, "_rdy"}, 32'(req_ready_o), 32'd1);
        req_valid_i    = 1'b1;
        opd_unsigned_i = u;
        op_mod_i       = m;
        dividend_i     = a;
        divisor_i      = b;
        @(posedge clk);
        #1 req_valid_i = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!resp_valid_o && lat < 100);
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_res"}, result_o, exp);
        if (hold > 0) begin
            req_valid_i = 1'b1;
            dividend_i  = 32'd9;
            divisor_i   = 32'd3;
            repeat (hold) begin
                @(negedge clk);
                chk({tag, "_hv"}, 32'(resp_valid_o), 32'd1);
                chk({tag, "_hr"}, 32'(req_ready_o), 32'd0);
                chk({tag, "_hres"}, result_o, exp);
            end
        end
        resp_ready_i = 1'b1;
        @(posedge clk);
        #1;
        resp_ready_i = 1'b0;
        req_valid_i  = 1'b0;
        chk({tag, "_hs_v"}, 32'(resp_valid_o), 32'd0);
        chk({tag, "_hs_r"}, 32'(req_ready_o), 32'd1);
    endtask

    initial begin
        logic [31:0] a, b;
        logic        u, m;
        int          seen;

        repeat (3) @(negedge clk);
        chk("rst_rdy", 32'(req_ready_o), 32'd1);
        chk("rst_vld", 32'(resp_valid_o), 32'd0);
        chk("rst_res", result_o, 32'd0);
        rst_n = 1'b1;

        do_op("u_div", 1'b1, 1'b0, 32'd100, 32'd7, 0);
        do_op("u_mod", 1'b1, 1'b1, 32'd100, 32'd7, 0);
        do_op("s_m7d2", 1'b0, 1'b0, -32'sd7, 32'd2, 0);
        do_op("s_m7m2", 1'b0, 1'b1, -32'sd7, 32'd2, 0);
        do_op("s_7dm2", 1'b0, 1'b0, 32'd7, -32'sd2, 0);
        do_op("s_7mm2", 1'b0, 1'b1, 32'd7, -32'sd2, 0);
        do_op("ovf_d", 1'b0, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        do_op("ovf_m", 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        do_op("u_max1", 1'b1, 1'b0, 32'hFFFF_FFFF, 32'd1, 0);
        do_op("z_sd", 1'b0, 1'b0, 32'd55, 32'd0, 0);
        do_op("z_sm", 1'b0, 1'b1, 32'd55, 32'd0, 0);
        do_op("z_ud", 1'b1, 1'b0, 32'hDEAD_BEEF, 32'd0, 0);
        do_op("z_um", 1'b1, 1'b1, 32'hDEAD_BEEF, 32'd0, 0);
        do_op("hold", 1'b1, 1'b0, 32'd1000, 32'd9, 5);

        // Flush during CALC
        @(negedge clk);
        req_valid_i    = 1'b1;
        opd_unsigned_i = 1'b1;
        op_mod_i       = 1'b0;
        dividend_i     = 32'd100;
        divisor_i      = 32'd7;
        @(posedge clk);
        #1 req_valid_i = 1'b0;
        repeat (10) @(negedge clk);
        flush_i = 1'b1;
        @(posedge clk);
        #1 flush_i = 1'b0;
        chk("fl_rdy", 32'(req_ready_o), 32'd1);
        chk("fl_vld", 32'(resp_valid_o), 32'd0);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (resp_valid_o) seen++;
        end
        chk("fl_quiet", 32'(seen), 32'd0);
        do_op("fl_93", 1'b1, 1'b0, 32'd9, 32'd3, 0);

        // Flush while holding a response in DONE
        @(negedge clk);
        req_valid_i = 1'b1;
        divisor_i   = 32'd0;
        @(posedge clk);
        #1 req_valid_i = 1'b0;
        @(negedge clk);
        chk("fd_vld", 32'(resp_valid_o), 32'd1);
        flush_i = 1'b1;
        @(posedge clk);
        #1 flush_i = 1'b0;
        chk("fd_gone", 32'(resp_valid_o), 32'd0);
        chk("fd_rdy", 32'(req_ready_o), 32'd1);

        do_op("pre_rst", 1'b1, 1'b0, 32'd9, 32'd3, 0);

        // Asynchronous reset mid-CALC
        @(negedge clk);
        req_valid_i = 1'b1;
        dividend_i  = 32'd500;
        divisor_i   = 32'd7;
        @(posedge clk);
        #1 req_valid_i = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_rdy", 32'(req_ready_o), 32'd1);
        chk("ar_vld", 32'(resp_valid_o), 32'd0);
        chk("ar_res", result_o, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 40; i++) begin
            u = 1'($urandom_range(0, 1));
            m = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0: a = $urandom_range(0, 200);
                1: a = 32'h8000_0000;
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: b = 32'hFFFF_FFFF;
                2: b = $urandom_range(1, 15);
                default: b = $urandom;
            endcase
            do_op("rnd", u, m, a, b, (i % 8 == 0) ? 2 : 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
